// File: rtl/seq_cla_add_ctrl_pkg.sv
// Shared definitions for the sequential nibble-serial CLA adder:
// FSM state encodings, the nibble width and a helper that sizes
// the nibble index register.
package seq_cla_add_ctrl_pkg;

  // Width of one adder slice processed per RUN cycle.
  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to count nibbles 0..width/NIB_W-1, never less than one.
  function automatic int idx_width(input int width);
    int nibs;
    nibs = width / NIB_W;
    return (nibs > 1) ? $clog2(nibs) : 1;
  endfunction

endpackage

// File: rtl/seq_cla_add_ctrl_cla.sv
// cla_4_bit: single 4-bit carry-lookahead slice. Generate g = a & b and
// propagate p = a ^ b; every internal carry is a flat sum of products so
// no carry ripples between bit positions.
module cla_4_bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic       cout,
  output logic [3:0] sum
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign sum  = p ^ c[3:0];
  assign cout = c[4];

endmodule

// File: rtl/seq_cla_add_ctrl.sv
// seq_cla_add_ctrl: sequential adder that processes one 4-bit nibble per
// clock through a single cla_4_bit slice, LSB nibble first.
//   IDLE --start--> RUN (WIDTH/4 cycles) --> DONE (one cycle, done=1) --> IDLE
// Optional feature macro SEQ_ADD_SUB_EN: adds the sub port; sub=1 at start
// latches ~b and forces carry-in to 1 so the result is a - b.
module seq_cla_add_ctrl
  import seq_cla_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SEQ_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIBS  = WIDTH / NIB_W;
  localparam int IDX_W = idx_width(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBS - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [NIB_W-1:0] a_nib;
  logic [NIB_W-1:0] b_nib;
  logic [NIB_W-1:0] nib_sum;
  logic             nib_cout;
  logic             nib_c_msb;

  // Select the operand nibbles addressed by the current nibble index.
  // NOTE: every signal driven from always_comb gets a default before any
  // branch; a path that leaves it unassigned would infer a latch.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int k = 0; k < NIBS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        a_nib = a_q[k*NIB_W +: NIB_W];
        b_nib = b_q[k*NIB_W +: NIB_W];
      end
    end
  end

  cla_4_bit u_cla (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry_q),
    .cout (nib_cout),
    .sum  (nib_sum)
  );

  // Carry into the slice MSB recovered from its sum bit; on the last nibble
  // this is the carry into bit WIDTH-1 used for signed overflow.
  assign nib_c_msb = nib_sum[NIB_W-1] ^ a_nib[NIB_W-1] ^ b_nib[NIB_W-1];

  // Next-state and datapath update for IDLE / RUN / DONE.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_d     = a;
`ifdef SEQ_ADD_SUB_EN
          // Subtraction as a + ~b + 1; the external carry-in is ignored.
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
`else
          b_d     = b;
          carry_d = cin;
`endif
          sum_d   = '0;
          idx_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
        end
      end

      RUN: begin
        for (int k = 0; k < NIBS; k++) begin
          if (idx_q == IDX_W'(k)) begin
            sum_d[k*NIB_W +: NIB_W] = nib_sum;
          end
        end
        carry_d = nib_cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          idx_d   = '0;
          cout_d  = nib_cout;
          ovf_d   = nib_c_msb ^ nib_cout;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything and aborts a run.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_seq_cla_add_ctrl.sv
// Self-checking bench for seq_cla_add_ctrl (WIDTH=16). Stimulus pushes the
// arithmetic result expected for each accepted start into a queue; an
// independent monitor pops and compares whenever done is seen.
module tb_seq_cla_add_ctrl;

  localparam int WIDTH = 16;
  localparam int NIBS  = WIDTH / 4;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             sub = 1'b0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  seq_cla_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SEQ_ADD_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic ci, input logic s);
    exp_t   e;
    longint ux, uy, sx, sy, u, r;
    longint modv, smax, smin;
    modv = longint'(1) << WIDTH;
    smax = (longint'(1) << (WIDTH - 1)) - 1;
    smin = -(longint'(1) << (WIDTH - 1));
    ux = longint'(x);
    uy = longint'(y);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (s) begin
      u      = ux - uy;
      r      = sx - sy;
      e.cout = (ux >= uy);
    end else begin
      u      = ux + uy + longint'(ci);
      r      = sx + sy + longint'(ci);
      e.cout = (u >= modv);
    end
    e.sum = WIDTH'(((u % modv) + modv) % modv);
    e.ovf = (r > smax) || (r < smin);
    return e;
  endfunction

  // Monitor: exclusivity of busy/done and result comparison on every done.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (busy || done) check("busy_done_exclusive", 64'(busy & done), 64'd0);
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("sum",  64'(sum),  64'(e.sum));
          check("cout", 64'(cout), 64'(e.cout));
          check("ovf",  64'(ovf),  64'(e.ovf));
        end
      end
    end
  end

  task automatic wait_idle();
    int guard = 0;
    while ((busy || done) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) check("wait_idle_timeout", 64'd1, 64'd0);
  endtask

  // One operation: issue start from IDLE, scramble inputs afterwards,
  // optionally re-pulse start in RUN cycle 2 or abort with reset there.
  task automatic do_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                       input logic ci, input logic s, input bit restart, input bit abort);
    int lat;
    int busy_cnt;
    wait_idle();
    a = x; b = y; cin = ci; sub = s; start = 1'b1;
    if (!abort) exp_q.push_back(model(x, y, ci, s));
    @(negedge clk);
    start = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
`ifdef SEQ_ADD_SUB_EN
    sub = 1'($urandom);
`endif
    lat = 1;
    busy_cnt = 0;
    while (!done && lat < 20) begin
      if (busy) busy_cnt++;
      if (abort && lat == 2) begin
        #2 rst = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_sum",  64'(sum),  64'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("abort_idle", 64'(busy | done), 64'd0);
        return;
      end
      if (restart && lat == 2) begin
        start = 1'b1;
        a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check("done_latency", 64'(lat), 64'(NIBS + 1));
    check("busy_cycles", 64'(busy_cnt), 64'(NIBS));
    @(negedge clk);
    check("idle_after_done", 64'(busy | done), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset values, both before the first edge and with the clock running.
    #3;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_sum",  64'(sum),  64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    check("rst_ovf",  64'(ovf),  64'd0);
    start = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy_clk", 64'(busy), 64'd0);
    check("rst_sum_clk",  64'(sum),  64'd0);
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // Directed cases.
    do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op(16'h8000, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b0);
    do_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef SEQ_ADD_SUB_EN
    do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, 1'b0);
    do_op(16'h0007, 16'h0005, 1'b1, 1'b1, 1'b0, 1'b0);
    do_op(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0);
`endif

    // Start re-pulsed in RUN must be ignored.
    do_op(16'hA5A5, 16'h0F0F, 1'b1, 1'b0, 1'b1, 1'b0);
    // Reset mid-run aborts; the following operation completes normally.
    do_op(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, 1'b1);
    do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized operations.
    for (int i = 0; i < 25; i++) begin
      logic s;
      s = 1'b0;
`ifdef SEQ_ADD_SUB_EN
      s = 1'($urandom);
`endif
      do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), s, 1'b0, 1'b0);
    end

    // Back-to-back with start held high: one acceptance every NIBS+2 cycles.
    wait_idle();
    for (int i = 0; i <= 3 * (NIBS + 2); i++) begin
      a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
      sub = 1'b0;
`ifdef SEQ_ADD_SUB_EN
      sub = 1'($urandom);
`endif
      start = 1'b1;
      if (i % (NIBS + 2) == 0) exp_q.push_back(model(a, b, cin, sub));
      @(negedge clk);
    end
    start = 1'b0;
    begin
      int guard = 0;
      while (exp_q.size() != 0 && guard < 30) begin
        @(negedge clk);
        guard++;
      end
    end
    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_cla_add_ctrl.md
SEQ_CLA_ADD_CTRL -- requirements
Module: seq_cla_add_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning operand width in bits; it SHALL be a multiple of 4 and at least 8.
REQ-002 Port clk SHALL be an input, 1 bit wide: the single clock; all state updates on its rising edge.
REQ-003 Port rst SHALL be an input, 1 bit wide: reset, asynchronous and active-high.
REQ-004 Port start SHALL be an input, 1 bit wide: operation request; sampled only in IDLE.
REQ-005 Ports a and b SHALL be inputs, WIDTH bits wide: operands, captured on the accepted start.
REQ-006 Port cin SHALL be an input, 1 bit wide: carry-in, captured on the accepted start.
REQ-007 Port sub SHALL be an input, 1 bit wide: subtract request; it SHALL be present only when SEQ_ADD_SUB_EN is defined.
REQ-008 Port busy SHALL be an output, 1 bit wide: high while in RUN.
REQ-009 Port done SHALL be an output, 1 bit wide: one-cycle pulse when the result is valid.
REQ-010 Port sum SHALL be an output, WIDTH bits wide: the result, held until the next accepted start.
REQ-011 Ports cout and ovf SHALL be outputs, 1 bit wide each: unsigned carry-out and signed overflow, held with sum.

Function
REQ-012 The FSM SHALL have states IDLE, RUN and DONE only.
REQ-013 Transitions SHALL be IDLE->RUN on start=1; RUN->DONE after nibble index WIDTH/4-1 completes; DONE->IDLE unconditionally; all other cases hold state.
REQ-014 An accepted start SHALL latch a, b and cin, clear sum, and set the nibble index to 0.
REQ-015 Each RUN cycle SHALL add one 4-bit nibble (index k) with a single 4-bit carry-lookahead adder, write sum[4k+3:4k] and register the nibble carry as carry-in for k+1.
REQ-016 Latency: start sampled at edge N -> busy=1 for cycles N+1..N+WIDTH/4 -> done=1 during cycle N+WIDTH/4+1.
REQ-017 cout SHALL be the carry out of the final nibble.
REQ-018 ovf SHALL equal the carry into bit WIDTH-1 XOR cout; it SHALL be computed in the final RUN cycle.
REQ-019 start SHALL be ignored in RUN and DONE, with no queuing and no effect on operands.
REQ-020 Operand input changes after acceptance SHALL have no effect on the result.
REQ-021 busy and done SHALL never be high together; busy=0 in IDLE and DONE.

Reset
REQ-022 rst=1 SHALL force IDLE immediately, independent of clk, and abort any operation in progress.
REQ-023 During rst, outputs SHALL be busy=0, done=0, sum=0, cout=0, ovf=0; the nibble index, carry register and operand registers SHALL be 0.
REQ-024 The first accepted start SHALL be on the first clk rising edge after rst deasserts with start=1.

Configuration
REQ-025 With SEQ_ADD_SUB_EN defined, sub=1 at start SHALL latch b inverted and force the carry-in to 1, giving a-b; cin SHALL be ignored in that case.
REQ-026 With SEQ_ADD_SUB_EN defined, cout SHALL be the raw carry, so cout=1 means no borrow, and ovf SHALL follow REQ-018.
REQ-027 Without SEQ_ADD_SUB_EN, the sub port and inversion logic SHALL be absent, and behaviour SHALL be add-only.

Structure
REQ-028 The shared include file SHALL hold the state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the nibble width constant 4.
REQ-029 The nibble adder SHALL be a single instantiated sub-module, cla_4_bit, with ports a[3:0], b[3:0], cin, cout, sum[3:0], g=a&b and p=a^b lookahead; no other sub-modules are permitted.
REQ-030 The nibble index register SHALL be ceil(log2(WIDTH/4)) bits wide, minimum 1.

Verification (WIDTH=16)
REQ-031 a=0x1234, b=0x4321, cin=0 -> done on cycle 5 after start, sum=0x5555, cout=0, ovf=0; busy high for exactly 4 cycles.
REQ-032 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0; a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
REQ-033 Start accepted, then start pulsed again with new operands in RUN cycle 2 -> the first result only, one done pulse, and no second operation started.
REQ-034 rst asserted during RUN cycle 2 -> busy=0 and sum=0 immediately, with no done pulse; the next start completes normally.
REQ-035 With SEQ_ADD_SUB_EN: a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0; a=0x0007, b=0x0005, sub=1 -> sum=0x0002, cout=1.
REQ-036 Back-to-back starts, with start held high continuously -> a new operation is accepted every WIDTH/4+2 cycles, each with a correct result.
